// File: rtl/aes_pkg.sv
// aes_pkg: shared AES arithmetic (S-box, xtime, Rcon) and parameter legality for the cipher blocks.
package aes_pkg;
  localparam int AES_NB = 4;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_DONE} aes_state_t;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as a^254 (square-and-multiply), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic bit aes_legal(input int nk, input int nr);
    return (nk == 4 || nk == 6 || nk == 8) && nr == nk + 6;
  endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational forward round; final_round bypasses MixColumns.
module aes_round import aes_pkg::*; (
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);
  logic [7:0]   w_sr [16];
  logic [127:0] w_mc;
  // Byte k = 4*col + row; ShiftRows pulls row r from column (c + r) mod 4.
  always_comb begin
    w_sr = '{default: '0};
    w_mc = '0;
    for (int k = 0; k < 16; k++)
      w_sr[k] = sbox(state[127-8*(4*(((k/4) + (k%4)) % 4) + (k%4)) -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_mc[127-8*(4*c+r) -: 8] = final_round ? w_sr[4*c+r] :
          xtime(w_sr[4*c+r] ^ w_sr[4*c+(r+1)%4]) ^ w_sr[4*c+(r+1)%4] ^ w_sr[4*c+(r+2)%4] ^ w_sr[4*c+(r+3)%4];
  end
  assign next_state = w_mc ^ round_key;
endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128/192/256 encryptor; expands the key one word per cycle,
// then runs one round per cycle, with valid/ready on both sides.
module aes_cipher_iter import aes_pkg::*; #(
  parameter int Nb = 4,
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in,
  input  logic [32*Nk-1:0] Key,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out
);
  localparam int NW = Nb * (Nr + 1);
  if (Nb != AES_NB || !aes_legal(Nk, Nr)) begin : g_bad_params
    $error("aes_cipher_iter: illegal Nb/Nk/Nr combination");
  end
  aes_state_t   r_fsm, w_nxt;
  logic [127:0] r_st, w_round, w_rk;
  logic [31:0]  r_w [NW];
  logic [5:0]   r_i, w_im1, w_ink, w_imod, w_rb;
  logic [3:0]   r_r, w_idiv;
  logic [31:0]  w_prev, w_rot, w_sub, w_temp;
  always_comb begin
    w_nxt = r_fsm;
    w_nxt = r_fsm == S_IDLE   ? (in_valid ? S_EXPAND : S_IDLE) :
            r_fsm == S_EXPAND ? (r_i == 6'(NW-1) ? S_ROUND : S_EXPAND) :
            r_fsm == S_ROUND  ? (r_r == 4'(Nr) ? S_DONE : S_ROUND) :
                                (out_ready ? S_IDLE : S_DONE);
    in_ready  = r_fsm == S_IDLE;
    out_valid = r_fsm == S_DONE;
  end
  // Key schedule step for word i: RotWord/SubWord/Rcon every Nk words, extra SubWord mid-block for AES-256.
  always_comb begin
    w_im1  = r_i - 6'd1;
    w_ink  = r_i - 6'(Nk);
    w_imod = r_i % 6'(Nk);
    w_idiv = 4'(r_i / 6'(Nk));
    w_prev = r_w[w_im1];
    w_rot  = w_imod == 6'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    w_temp = w_imod == 6'd0 ? w_sub ^ {RCON[w_idiv], 24'h0} :
             (Nk == 8 && w_imod == 6'd4) ? w_sub : w_prev;
  end
  assign w_rb = {r_r, 2'b00};
  assign w_rk = {r_w[w_rb], r_w[w_rb+6'd1], r_w[w_rb+6'd2], r_w[w_rb+6'd3]};
  aes_round u_round (
    .state      (r_st),
    .round_key  (w_rk),
    .final_round(r_r == 4'(Nr)),
    .next_state (w_round)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
      r_st  <= '0;
      r_i   <= '0;
      r_r   <= '0;
    end else begin
      r_fsm <= w_nxt;
      if (r_fsm == S_IDLE && in_valid) begin
        r_st <= in ^ Key[32*Nk-1 -: 128];
        r_i  <= 6'(Nk);
      end
      if (r_fsm == S_EXPAND) begin
        r_i <= r_i + 6'd1;
        if (r_i == 6'(NW-1)) r_r <= 4'd1;
      end
      if (r_fsm == S_ROUND) begin
        r_st <= w_round;
        r_r  <= r_r + 4'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (r_fsm == S_IDLE && in_valid)
      for (int j = 0; j < Nk; j++) r_w[j] <= Key[32*(Nk-j)-1 -: 32];
    else if (r_fsm == S_EXPAND)
      r_w[r_i] <= r_w[w_ink] ^ w_temp;
  end
  assign out = r_st;
endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES forward cipher (FIPS-197 encryption), parameterised for AES-128/192/256 with the same `Nb`/`Nk`/`Nr` parameter set as `inversecipher`. It is the encrypt-side counterpart to that decrypt block, with a valid/ready block interface for the datapath. It first expands the key one word per cycle into a round-key store, then executes one round per cycle. Ciphertext from this block round-trips through `inversecipher` with the same key.

## Interface
- `Nb`, 4: state columns; only 4 is legal.
- `Nk`, 4: key words; legal values are 4, 6, 8.
- `Nr`, 10: rounds; must equal `Nk+6`. Any other combination is an elaboration error.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: plaintext and key are valid.
- `in_ready` out 1: block is idle and will accept a new input.
- `in` in 128: plaintext; `in[127:120]` is state byte 0, column-major per FIPS-197.
- `Key` in 32*Nk: cipher key; `w[0] = Key[32*Nk-1 -: 32]`.
- `out_valid` out 1: ciphertext is valid.
- `out_ready` in 1: consumer accepts the ciphertext.
- `out` out 128: ciphertext, same byte order as `in`.

## Operation
- **States**: IDLE, EXPAND, ROUND, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, register:
    - `Key` words into `w[0..Nk-1]`;
    - `state <= in ^ Key[32*Nk-1 -: 128]` (AddRoundKey 0);
    - `i <= Nk`.
  - Go to EXPAND.
- **EXPAND**
  - Computes one word per cycle: `w[i] = w[i-Nk] ^ temp`.
  - `temp` is chosen as follows:
    - `i mod Nk == 0`: `SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk]`;
    - `Nk == 8 && i mod Nk == 4`: `SubWord(w[i-1])`;
    - otherwise: `w[i-1]`.
  - After writing `w[Nb*(Nr+1)-1]`, set `r <= 1` and go to ROUND.
  - Cycle count E = `Nb*(Nr+1)-Nk`: 40, 46 or 52 cycles.
- **ROUND**
  - Each cycle: `state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), w[4r..4r+3])`.
  - When `r == Nr`, MixColumns is omitted.
  - `r` increments each cycle; after round `Nr`, go to DONE.
- **DONE**
  - `out_valid` = 1, `in_ready` = 0, and `out` = `state`, held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- **No overlap**: a new block is never accepted while one is in flight or held in DONE.
- **Key store**: holds 60 x 32 bits maximum. No key reuse between blocks; every block re-expands its key.
- **Inputs while busy**: `in_valid` outside IDLE is ignored. `in` and `Key` need only be stable in the accept cycle.

## Timing
- **Reset values**: state IDLE, `in_ready` = 1, `out_valid` = 0, `out` = 0, `r` = 0, `i` = 0.
- **Reset mid-operation** (EXPAND, ROUND or DONE):
  - the current block is dropped;
  - `out_valid` = 0 and `in_ready` = 1 from the cycle after reset;
  - no partial result is emitted.
- **Latency**: with acceptance at edge t0, `out_valid` rises after edge t0+E+Nr.
  - AES-128: 50 cycles.
  - AES-192: 58 cycles.
  - AES-256: 66 cycles.
- **Handshake**:
  - `out_valid` stays high with `out` unchanged through any number of `out_ready = 0` cycles.
  - If `out_ready` is already high when `out_valid` rises, the transfer completes in that cycle.
  - `in_ready` returns to 1 on the cycle after the output transfer.
- **Throughput**: one block per E+Nr+2 cycles minimum, counting the DONE cycle and the IDLE accept cycle.
- **Outputs**: registered, with no combinational path from inputs to `out`.

## Structure
- **Package `aes_pkg`** (shared with `inversecipher`):
  - S-box function;
  - `xtime`;
  - Rcon table, entries 1..10;
  - `AES_NB = 4`;
  - the legal (`Nk`, `Nr`) pairs.
- **Sub-module `aes_round`** (combinational):
  - inputs: `state`, `round_key`, `final_round`;
  - output: next state.
- **Top-level contents**: FSM, counters `i`/`r`, key store, and the SubWord/RotWord key-expansion logic, which uses 4 package S-box lookups.

## Test plan
- **AES-128 Appendix C vector**: `in = 00112233445566778899aabbccddeeff`, `Key = 000102030405060708090a0b0c0d0e0f` -> `out = 69c4e0d86a7b0430d8cdb78070b4c55a`, `out_valid` exactly 50 cycles after accept.
- **AES-192 Appendix C vector**: same plaintext, `Key = 000102…1617` -> `dda97ca4864cdfe06eaf70a0ec0d7191` after 58 cycles.
- **AES-256 Appendix C vector**: same plaintext, `Key = 000102…1e1f` -> `8ea2b7ca516745bfeafc49904b496089` after 66 cycles.
- **Backpressure with Appendix B vector**: `in = 3243f6a8885a308d313198a2e0370734`, `Key = 2b7e151628aed2a6abf7158809cf4f3c`, `out_ready` held 0 for 20 cycles -> `out = 3925841d02dc09fbdc118597196a0b32` held stable, `in_ready` stays 0 and a concurrent `in_valid` is ignored.
- **Reset mid-operation**: assert `rst` during EXPAND and again during ROUND -> next cycle `in_ready` = 1, `out_valid` = 0; a fresh AES-128 vector then produces the correct result.
- **Back-to-back and round trip**: 100 random AES-128/192/256 blocks with random `out_ready`; each ciphertext fed to `inversecipher` with the same key returns the original plaintext.
